// File: rtl/lrp_alpha_sel.sv
// Chase-decoder front end: tracks the three least-reliable positions of a codeword and emits
// alpha^j, alpha^3j, alpha^5j for each. Define LRP_POS_OUT_EN to also output the positions j.
module lrp_alpha_sel #(
    parameter int unsigned     GF_LEN    = 10,
    parameter logic [GF_LEN:0] PRIM_POLY = 11'h409,
    parameter int unsigned     CODE_LEN  = 1023,
    parameter int unsigned     REL_W     = 4
) (
    input  logic                          clk,
    input  logic                          in_ctr_rstn,
    input  logic                          in_ctr_Srst,
    input  logic                          in_ctr_en,
    input  logic                          in_ctr_start,
    input  logic                          in_ctr_valid,
    input  logic [REL_W-1:0]              in_rel,
    output logic [3*GF_LEN-1:0]           out_alpha1,
    output logic [3*GF_LEN-1:0]           out_alpha2,
    output logic [3*GF_LEN-1:0]           out_alpha3,
`ifdef LRP_POS_OUT_EN
    output logic [3*$clog2(CODE_LEN)-1:0] out_lrp_pos,
`endif
    output logic                          out_done,
    output logic                          out_busy
);

    localparam int unsigned   PW         = $clog2(CODE_LEN);
    localparam int unsigned   AW         = 3 * GF_LEN;
    localparam logic [PW-1:0] LAST_POS   = PW'(CODE_LEN - 1);
    localparam logic [0:0]    ST_IDLE    = 1'b0;
    localparam logic [0:0]    ST_COLLECT = 1'b1;

    // Constant GF multiply by alpha^n: n shift-and-reduce steps, pure wiring after elaboration.
    function automatic logic [GF_LEN-1:0] mul_alpha_n(input logic [GF_LEN-1:0] x,
                                                      input int unsigned       n);
        logic [GF_LEN:0]   t;
        logic [GF_LEN-1:0] r;
        r = x;
        for (int unsigned i = 0; i < n; i++) begin
            t = {r, 1'b0};
            if (t[GF_LEN]) t = t ^ PRIM_POLY;
            r = t[GF_LEN-1:0];
        end
        return r;
    endfunction

    logic [0:0]              state_q, state_d;
    logic [PW-1:0]           pos_q, pos_d;
    logic [GF_LEN-1:0]       run1_q, run1_d, run3_q, run3_d, run5_q, run5_d;
    logic [2:0]              vld_q, vld_d;
    logic [2:0][REL_W-1:0]   rel_q, rel_d;
    logic [2:0][AW-1:0]      pw_q, pw_d;
`ifdef LRP_POS_OUT_EN
    logic [2:0][PW-1:0]      spos_q, spos_d;
`endif

    logic              accept, start_acc, coll_acc, ins, last_acc;
    logic [GF_LEN-1:0] nxt1, nxt3, nxt5;
    logic [AW-1:0]     new_pw;
    logic [2:0]        base_vld, gt;

    always_comb begin
        accept    = in_ctr_en & in_ctr_valid;
        start_acc = accept & in_ctr_start;
        coll_acc  = accept & ~in_ctr_start & (state_q == ST_COLLECT);
        ins       = start_acc | coll_acc;
        last_acc  = coll_acc & ((pos_q + PW'(1)) == LAST_POS);

        nxt1   = start_acc ? GF_LEN'(1) : mul_alpha_n(run1_q, 1);
        nxt3   = start_acc ? GF_LEN'(1) : mul_alpha_n(run3_q, 3);
        nxt5   = start_acc ? GF_LEN'(1) : mul_alpha_n(run5_q, 5);
        new_pw = {nxt5, nxt3, nxt1};

        // A start discards the previous contents, so every slot looks empty to it.
        base_vld = start_acc ? 3'b000 : vld_q;
        for (int k = 0; k < 3; k++) begin
            gt[k] = ~base_vld[k] | (rel_q[k] > in_rel);
        end

        state_d = state_q;
        pos_d   = pos_q;
        run1_d  = run1_q;
        run3_d  = run3_q;
        run5_d  = run5_q;
        vld_d   = vld_q;
        rel_d   = rel_q;
        pw_d    = pw_q;
`ifdef LRP_POS_OUT_EN
        spos_d  = spos_q;
`endif

        if (ins) begin
            state_d = last_acc ? ST_IDLE : ST_COLLECT;
            pos_d   = start_acc ? '0 : pos_q + PW'(1);
            run1_d  = nxt1;
            run3_d  = nxt3;
            run5_d  = nxt5;
            vld_d   = base_vld;

            // Sorted insert; strict compare keeps the earlier position ahead on ties.
            if (gt[1]) begin
                vld_d[2] = base_vld[1];
                rel_d[2] = rel_q[1];
                pw_d[2]  = pw_q[1];
            end else if (gt[2]) begin
                vld_d[2] = 1'b1;
                rel_d[2] = in_rel;
                pw_d[2]  = new_pw;
            end
            if (gt[0]) begin
                vld_d[1] = base_vld[0];
                rel_d[1] = rel_q[0];
                pw_d[1]  = pw_q[0];
            end else if (gt[1]) begin
                vld_d[1] = 1'b1;
                rel_d[1] = in_rel;
                pw_d[1]  = new_pw;
            end
            if (gt[0]) begin
                vld_d[0] = 1'b1;
                rel_d[0] = in_rel;
                pw_d[0]  = new_pw;
            end
`ifdef LRP_POS_OUT_EN
            if (gt[1])      spos_d[2] = spos_q[1];
            else if (gt[2]) spos_d[2] = pos_d;
            if (gt[0])      spos_d[1] = spos_q[0];
            else if (gt[1]) spos_d[1] = pos_d;
            if (gt[0])      spos_d[0] = pos_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge in_ctr_rstn) begin
        if (!in_ctr_rstn) begin
            state_q     <= ST_IDLE;
            pos_q       <= '0;
            run1_q      <= '0;
            run3_q      <= '0;
            run5_q      <= '0;
            vld_q       <= '0;
            rel_q       <= '0;
            pw_q        <= '0;
            out_alpha1  <= '0;
            out_alpha2  <= '0;
            out_alpha3  <= '0;
            out_done    <= 1'b0;
`ifdef LRP_POS_OUT_EN
            spos_q      <= '0;
            out_lrp_pos <= '0;
`endif
        end else if (in_ctr_Srst) begin
            state_q     <= ST_IDLE;
            pos_q       <= '0;
            run1_q      <= '0;
            run3_q      <= '0;
            run5_q      <= '0;
            vld_q       <= '0;
            rel_q       <= '0;
            pw_q        <= '0;
            out_alpha1  <= '0;
            out_alpha2  <= '0;
            out_alpha3  <= '0;
            out_done    <= 1'b0;
`ifdef LRP_POS_OUT_EN
            spos_q      <= '0;
            out_lrp_pos <= '0;
`endif
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            run1_q   <= run1_d;
            run3_q   <= run3_d;
            run5_q   <= run5_d;
            vld_q    <= vld_d;
            rel_q    <= rel_d;
            pw_q     <= pw_d;
            out_done <= last_acc;
            if (last_acc) begin
                out_alpha1 <= pw_d[0];
                out_alpha2 <= pw_d[1];
                out_alpha3 <= pw_d[2];
            end
`ifdef LRP_POS_OUT_EN
            spos_q <= spos_d;
            if (last_acc) out_lrp_pos <= {spos_d[2], spos_d[1], spos_d[0]};
`endif
        end
    end

    assign out_busy = (state_q == ST_COLLECT);

endmodule

// File: tb/tb_lrp_alpha_sel.sv
// Bench for lrp_alpha_sel: a codeword-level LRP model checked every cycle, plus literal pins.
module tb_lrp_alpha_sel;

    localparam int GF_LEN   = 10;
    localparam int CODE_LEN = 1023;
    localparam int REL_W    = 4;
    localparam int PW       = $clog2(CODE_LEN);
    localparam int AW       = 3 * GF_LEN;

    logic             clk = 1'b0;
    logic             rstn, srst, en, start, valid;
    logic [REL_W-1:0] rel;
    logic [AW-1:0]    out_alpha1, out_alpha2, out_alpha3;
    logic             out_done, out_busy;
`ifdef LRP_POS_OUT_EN
    logic [3*PW-1:0]  out_lrp_pos;
`endif

    always #5 clk = ~clk;

    lrp_alpha_sel #(
        .GF_LEN    (GF_LEN),
        .PRIM_POLY (11'h409),
        .CODE_LEN  (CODE_LEN),
        .REL_W     (REL_W)
    ) dut (
        .clk          (clk),
        .in_ctr_rstn  (rstn),
        .in_ctr_Srst  (srst),
        .in_ctr_en    (en),
        .in_ctr_start (start),
        .in_ctr_valid (valid),
        .in_rel       (rel),
        .out_alpha1   (out_alpha1),
        .out_alpha2   (out_alpha2),
        .out_alpha3   (out_alpha3),
`ifdef LRP_POS_OUT_EN
        .out_lrp_pos  (out_lrp_pos),
`endif
        .out_done     (out_done),
        .out_busy     (out_busy)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int pow_tab[CODE_LEN];
    int cyc = 0;
    int done_cnt = 0, done_last = 0, done_prev = 0, start_cyc = 0;

    // model state
    int            m_rel[CODE_LEN];
    int            m_pos = 0;
    bit            m_active = 1'b0;
    bit            exp_done = 1'b0;
    logic [AW-1:0] exp_a[3] = '{default: '0};
    logic [3*PW-1:0] exp_pos = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    function automatic logic [AW-1:0] exp_pack(input int j);
        return {10'(pow_tab[(5 * j) % CODE_LEN]), 10'(pow_tab[(3 * j) % CODE_LEN]),
                10'(pow_tab[j])};
    endfunction

    task automatic model_clear();
        m_active = 1'b0;
        exp_done = 1'b0;
        for (int k = 0; k < 3; k++) exp_a[k] = '0;
        exp_pos = '0;
    endtask

    // Pick the three smallest reliabilities, earliest position first on ties.
    task automatic model_finish();
        int ch[3];
        int best;
        for (int s = 0; s < 3; s++) begin
            best = -1;
            for (int p = 0; p < CODE_LEN; p++) begin
                if ((s > 0 && p == ch[0]) || (s > 1 && p == ch[1])) continue;
                if (best < 0 || m_rel[p] < m_rel[best]) best = p;
            end
            ch[s] = best;
            exp_a[s] = exp_pack(best);
        end
        exp_pos = {PW'(ch[2]), PW'(ch[1]), PW'(ch[0])};
    endtask

    initial forever begin
        @(posedge clk or negedge rstn);
        if (!rstn) model_clear();
        else begin
            exp_done = 1'b0;
            if (srst) model_clear();
            else if (en && valid) begin
                if (start) begin
                    m_active = 1'b1;
                    m_pos = 0;
                    m_rel[0] = int'(rel);
                end else if (m_active) begin
                    m_pos++;
                    m_rel[m_pos] = int'(rel);
                    if (m_pos == CODE_LEN - 1) begin
                        model_finish();
                        exp_done = 1'b1;
                        m_active = 1'b0;
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        chk("done", 64'(out_done), 64'(exp_done));
        chk("busy", 64'(out_busy), 64'(m_active));
        chk("alpha1", 64'(out_alpha1), 64'(exp_a[0]));
        chk("alpha2", 64'(out_alpha2), 64'(exp_a[1]));
        chk("alpha3", 64'(out_alpha3), 64'(exp_a[2]));
`ifdef LRP_POS_OUT_EN
        chk("lrp_pos", 64'(out_lrp_pos), 64'(exp_pos));
`endif
        if (out_done) begin
            done_cnt++;
            done_prev = done_last;
            done_last = cyc;
        end
    end

    function automatic logic [REL_W-1:0] rel_of(input int tid, input int p);
        case (tid)
            2:       return (p == 100) ? 4'd0 : (p == 700) ? 4'd1 : (p == 5) ? 4'd2 : 4'd15;
            3:       return 4'd7;
            5:       return (p == 10 || p == 20 || p == 30) ? 4'd0 : 4'd15;
            6:       return (p == 900) ? 4'd1 : (p == 1000) ? 4'd2 : (p == 50) ? 4'd3 : 4'd9;
            7:       return 4'(p % 16);
            8:       return 4'(15 - (p % 16));
            default: return 4'(p % 13 + 2);
        endcase
    endfunction

    task automatic drive(input logic e, input logic v, input logic s, input logic [REL_W-1:0] r);
        en = e;
        valid = v;
        start = s;
        rel = r;
        @(negedge clk);
    endtask

    task automatic send_word(input int tid, input int nstall);
        bit stall_at[CODE_LEN];
        int k;
        int r;
        k = 0;
        while (k < nstall) begin
            r = int'($urandom_range(1, CODE_LEN - 1));
            if (!stall_at[r]) begin
                stall_at[r] = 1'b1;
                k++;
            end
        end
        start_cyc = cyc;
        for (int p = 0; p < CODE_LEN; p++) begin
            // stall cycle presents a bogus start that must be ignored
            if (stall_at[p]) drive(1'b0, 1'b1, 1'b1, '0);
            drive(1'b1, 1'b1, p == 0, rel_of(tid, p));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, '0);
    endtask

    initial begin
        int d0;
        int v;
        rstn = 1'b0; srst = 1'b0; en = 1'b0; start = 1'b0; valid = 1'b0; rel = '0;
        v = 1;
        for (int k = 0; k < CODE_LEN; k++) begin
            pow_tab[k] = v;
            v = v * 2;
            if (v >= 1024) v = v ^ 'h409;
        end
        chk("pow_a1", 64'(pow_tab[1]), 64'd2);
        chk("pow_a3", 64'(pow_tab[3]), 64'd8);
        chk("pow_a10", 64'(pow_tab[10]), 64'd9);
        chk("pow_a1022", 64'(pow_tab[1022]), 64'd516);
        chk("pow_wrap", 64'(v), 64'd1);

        #1;
        chk("rst_alpha1", 64'(out_alpha1), 64'd0);
        chk("rst_done", 64'(out_done), 64'd0);
        chk("rst_busy", 64'(out_busy), 64'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // LRPs at positions 100, 700, 5
        d0 = done_cnt;
        send_word(2, 0);
        idle(3);
        chk("t2_done_cnt", 64'(done_cnt), 64'(d0 + 1));
        chk("t2_latency", 64'(done_last - start_cyc), 64'(CODE_LEN));
        chk("t2_a1", 64'(out_alpha1), 64'(exp_pack(100)));
        chk("t2_a2", 64'(out_alpha2), 64'(exp_pack(700)));
        chk("t2_a3", 64'(out_alpha3), 64'(exp_pack(5)));

        // async reset mid-codeword
        for (int p = 0; p < 300; p++) drive(1'b1, 1'b1, p == 0, rel_of(4, p));
        idle(1);
        chk("pre_rst_busy", 64'(out_busy), 64'd1);
        @(posedge clk);
        #3 rstn = 1'b0;
        #1;
        chk("arst_alpha1", 64'(out_alpha1), 64'd0);
        chk("arst_alpha2", 64'(out_alpha2), 64'd0);
        chk("arst_alpha3", 64'(out_alpha3), 64'd0);
        chk("arst_busy", 64'(out_busy), 64'd0);
        chk("arst_done", 64'(out_done), 64'd0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        // ties: positions 0,1,2
        d0 = done_cnt;
        send_word(3, 0);
        idle(3);
        chk("tie_done_cnt", 64'(done_cnt), 64'(d0 + 1));
        chk("tie_a1", 64'(out_alpha1), 64'({10'd1, 10'd1, 10'd1}));
        chk("tie_a2", 64'(out_alpha2), 64'({10'd32, 10'd8, 10'd2}));
        chk("tie_a3", 64'(out_alpha3), 64'({10'd9, 10'd64, 10'd4}));

        // stalls: same data, done delayed by exactly the stall cycles
        d0 = done_cnt;
        send_word(2, 10);
        idle(3);
        chk("stall_done_cnt", 64'(done_cnt), 64'(d0 + 1));
        chk("stall_latency", 64'(done_last - start_cyc), 64'(CODE_LEN + 10));
        chk("stall_a1", 64'(out_alpha1), 64'(exp_pack(100)));
        chk("stall_a2", 64'(out_alpha2), 64'(exp_pack(700)));
        chk("stall_a3", 64'(out_alpha3), 64'(exp_pack(5)));

        // restart at position 400
        d0 = done_cnt;
        for (int p = 0; p < 400; p++) drive(1'b1, 1'b1, p == 0, rel_of(5, p));
        send_word(6, 0);
        idle(3);
        chk("restart_done_cnt", 64'(done_cnt), 64'(d0 + 1));
        chk("restart_latency", 64'(done_last - start_cyc), 64'(CODE_LEN));
        chk("restart_a1", 64'(out_alpha1), 64'(exp_pack(900)));
        chk("restart_a2", 64'(out_alpha2), 64'(exp_pack(1000)));
        chk("restart_a3", 64'(out_alpha3), 64'(exp_pack(50)));

        // back-to-back codewords
        d0 = done_cnt;
        send_word(7, 0);
        send_word(8, 0);
        idle(3);
        chk("b2b_done_cnt", 64'(done_cnt), 64'(d0 + 2));
        chk("b2b_spacing", 64'(done_last - done_prev), 64'(CODE_LEN));
        chk("b2b_a1", 64'(out_alpha1), 64'(exp_pack(15)));
        chk("b2b_a2", 64'(out_alpha2), 64'(exp_pack(31)));
        chk("b2b_a3", 64'(out_alpha3), 64'(exp_pack(47)));

        idle(2);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
